// File: rtl/axi_tdd_monitor.sv
// axi_tdd_monitor
// Receive-side decoder for TDD timing. It watches the frame sync pulse and the
// channel levels, then reports for each frame the frame length and the first
// on and off offset of every channel, in the generator's counter units.
// Results are held for a register map through a valid/ack handshake.
//
// Ports:
//   clk, rst        monitor clock; asynchronous active-high reset
//   enable          level enable; dropping it discards the frame in progress
//   sync            one-cycle frame-start pulse
//   ch_pol          per-channel polarity (1 = active-low), taken only in IDLE
//   tdd_channel     observed channel levels
//   meas_ack        consumer acknowledge of the held result set
//   meas_valid      result set available, held until acknowledged
//   meas_overflow   sticky: a held result set was overwritten unacknowledged
//   frame_length    cycles between the last two syncs (saturates at all-ones)
//   t_on, t_off     first on/off offset; channel i at [i*RW +: RW], all-ones = none
//   ch_seen         channel was active during the frame
//   ch_multi        channel had more than one activation during the frame
//   state           IDLE=0, ARMED=1, RUN=2
module axi_tdd_monitor #(
  parameter int CHANNEL_COUNT = 8,
  parameter int REGISTER_WIDTH = 32,
  parameter logic [CHANNEL_COUNT-1:0] DEFAULT_POLARITY = {CHANNEL_COUNT{1'b0}}
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic                                   sync,
  input  logic [CHANNEL_COUNT-1:0]               ch_pol,
  input  logic [CHANNEL_COUNT-1:0]               tdd_channel,
  input  logic                                   meas_ack,
  output logic                                   meas_valid,
  output logic                                   meas_overflow,
  output logic [REGISTER_WIDTH-1:0]              frame_length,
  output logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] t_on,
  output logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] t_off,
  output logic [CHANNEL_COUNT-1:0]               ch_seen,
  output logic [CHANNEL_COUNT-1:0]               ch_multi,
  output logic [1:0]                             state
);

  localparam logic [REGISTER_WIDTH-1:0] ONES = {REGISTER_WIDTH{1'b1}};
  localparam logic [REGISTER_WIDTH-1:0] ZERO = {REGISTER_WIDTH{1'b0}};
  localparam logic [REGISTER_WIDTH-1:0] ONE  = {{(REGISTER_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} state_t;

  state_t                      state_r, state_nxt_s;
  logic                        open_s, close_s, run_s;
  logic [REGISTER_WIDTH-1:0]   counter_r, now_s;
  logic [CHANNEL_COUNT-1:0]    ch_pol_q, prev_r, act_s, rise_s, fall_s;

  // Per-frame shadows; only copied to the outputs when a frame closes.
  logic [CHANNEL_COUNT-1:0]    on_rec_r, off_rec_r, multi_r;
  logic [REGISTER_WIDTH-1:0]   t_on_sh_r  [CHANNEL_COUNT];
  logic [REGISTER_WIDTH-1:0]   t_off_sh_r [CHANNEL_COUNT];

  logic                                    meas_valid_r, meas_overflow_r;
  logic [REGISTER_WIDTH-1:0]               frame_length_r;
  logic [CHANNEL_COUNT*REGISTER_WIDTH-1:0] t_on_r, t_off_r;
  logic [CHANNEL_COUNT-1:0]                ch_seen_r, ch_multi_r;

  assign act_s  = tdd_channel ^ ch_pol_q;
  assign rise_s = act_s & ~prev_r;
  assign fall_s = ~act_s & prev_r;
  // A sync cycle is time 0 of the frame it opens.
  assign now_s  = sync ? ZERO : counter_r;

  // Next-state decode and the open/close/run strobes that drive capture.
  always_comb begin
    state_nxt_s = state_r;
    open_s      = 1'b0;
    close_s     = 1'b0;
    run_s       = 1'b0;
    if (!enable) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = ARMED;
        end
        ARMED: begin
          if (sync) begin
            state_nxt_s = RUN;
            open_s      = 1'b1;
          end else begin
            state_nxt_s = ARMED;
          end
        end
        RUN: begin
          state_nxt_s = RUN;
          if (sync) begin
            close_s = 1'b1;
          end else begin
            run_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State register, polarity sampling (IDLE only) and previous active level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      ch_pol_q <= DEFAULT_POLARITY;
      prev_r   <= {CHANNEL_COUNT{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      prev_r  <= act_s;
      if (state_r == IDLE) begin
        ch_pol_q <= ch_pol;
      end
    end
  end

  // Frame cycle counter: restarts at 1 after every sync, saturates in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_r <= ZERO;
    end else if (open_s || close_s) begin
      counter_r <= ONE;
    end else if (run_s) begin
      if (counter_r != ONES) begin
        counter_r <= counter_r + ONE;
      end
    end else if (state_nxt_s == IDLE) begin
      counter_r <= ZERO;
    end
  end

  // Shadow capture of first on/off edges and repeated activations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_rec_r  <= {CHANNEL_COUNT{1'b0}};
      off_rec_r <= {CHANNEL_COUNT{1'b0}};
      multi_r   <= {CHANNEL_COUNT{1'b0}};
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        t_on_sh_r[i]  <= ONES;
        t_off_sh_r[i] <= ONES;
      end
    end else if (open_s || close_s) begin
      // A channel active in the sync cycle (rising or held across the
      // boundary) is recorded as switched on at time 0 of the new frame.
      on_rec_r  <= act_s;
      off_rec_r <= {CHANNEL_COUNT{1'b0}};
      multi_r   <= {CHANNEL_COUNT{1'b0}};
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        t_on_sh_r[i]  <= ZERO;
        t_off_sh_r[i] <= ONES;
      end
    end else if (run_s) begin
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        if (rise_s[i]) begin
          if (!on_rec_r[i]) begin
            on_rec_r[i]  <= 1'b1;
            t_on_sh_r[i] <= now_s;
          end else begin
            multi_r[i] <= 1'b1;
          end
        end
        if (fall_s[i] && on_rec_r[i] && !off_rec_r[i]) begin
          off_rec_r[i]  <= 1'b1;
          t_off_sh_r[i] <= now_s;
        end
      end
    end
  end

  // Result registers, loaded from the shadows when a RUN frame closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_length_r <= ZERO;
      t_on_r         <= {(CHANNEL_COUNT*REGISTER_WIDTH){1'b1}};
      t_off_r        <= {(CHANNEL_COUNT*REGISTER_WIDTH){1'b1}};
      ch_seen_r      <= {CHANNEL_COUNT{1'b0}};
      ch_multi_r     <= {CHANNEL_COUNT{1'b0}};
    end else if (close_s) begin
      frame_length_r <= counter_r;
      ch_seen_r      <= on_rec_r;
      ch_multi_r     <= multi_r;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        t_on_r[i*REGISTER_WIDTH +: REGISTER_WIDTH]  <= on_rec_r[i]  ? t_on_sh_r[i]  : ONES;
        t_off_r[i*REGISTER_WIDTH +: REGISTER_WIDTH] <= off_rec_r[i] ? t_off_sh_r[i] : ONES;
      end
    end
  end

  // Valid/ack handshake; a close with a same-cycle ack is not an overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_valid_r    <= 1'b0;
      meas_overflow_r <= 1'b0;
    end else if (close_s) begin
      meas_valid_r <= 1'b1;
      if (meas_valid_r && !meas_ack) begin
        meas_overflow_r <= 1'b1;
      end else if (meas_valid_r && meas_ack) begin
        meas_overflow_r <= 1'b0;
      end
    end else if (meas_valid_r && meas_ack) begin
      meas_valid_r    <= 1'b0;
      meas_overflow_r <= 1'b0;
    end
  end

  assign state         = state_r;
  assign meas_valid    = meas_valid_r;
  assign meas_overflow = meas_overflow_r;
  assign frame_length  = frame_length_r;
  assign t_on          = t_on_r;
  assign t_off         = t_off_r;
  assign ch_seen       = ch_seen_r;
  assign ch_multi      = ch_multi_r;

endmodule

// File: tb/tb_axi_tdd_monitor.sv
// Testbench for axi_tdd_monitor: directed frame scenarios checked every cycle
// against a frame-history model, plus hand-computed literal expectations.
module tb_axi_tdd_monitor;
  localparam int CC = 8;
  localparam int RW = 32;
  localparam int WW = CC * RW;
  typedef logic [WW-1:0] wide_t;

  logic clk = 1'b0;
  logic rst, enable, sync, meas_ack;
  logic [CC-1:0] ch_pol, tdd_channel;
  logic meas_valid, meas_overflow;
  logic [RW-1:0] frame_length;
  logic [WW-1:0] t_on, t_off;
  logic [CC-1:0] ch_seen, ch_multi;
  logic [1:0] state;

  axi_tdd_monitor #(.CHANNEL_COUNT(CC), .REGISTER_WIDTH(RW), .DEFAULT_POLARITY(8'h00)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync(sync), .ch_pol(ch_pol),
    .tdd_channel(tdd_channel), .meas_ack(meas_ack), .meas_valid(meas_valid),
    .meas_overflow(meas_overflow), .frame_length(frame_length), .t_on(t_on),
    .t_off(t_off), .ch_seen(ch_seen), .ch_multi(ch_multi), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = -1;

  // Model: the active levels of every cycle of the open frame are kept as a
  // history; results are derived from that history when the frame closes.
  int            m_state;
  logic [CC-1:0] m_pol;
  logic [CC-1:0] hist[$];
  logic          m_valid, m_ovf;
  logic [RW-1:0] e_len;
  logic [WW-1:0] e_on, e_off;
  logic [CC-1:0] e_seen, e_multi;

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pol   = 8'h00;
    hist.delete();
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    e_len   = '0;
    e_on    = '1;
    e_off   = '1;
    e_seen  = '0;
    e_multi = '0;
  endtask

  task automatic model_close();
    e_len = RW'(hist.size());
    for (int i = 0; i < CC; i++) begin
      int on_t, off_t, rises;
      on_t = -1; off_t = -1; rises = 0;
      for (int k = 0; k < hist.size(); k++) begin
        if (hist[k][i] && (k == 0 || !hist[k-1][i])) rises++;
        if (on_t < 0 && hist[k][i]) on_t = k;
        else if (on_t >= 0 && off_t < 0 && !hist[k][i]) off_t = k;
      end
      e_seen[i]  = (on_t >= 0);
      e_multi[i] = (rises > 1);
      e_on[i*RW +: RW]  = (on_t >= 0)  ? RW'(on_t)  : {RW{1'b1}};
      e_off[i*RW +: RW] = (off_t >= 0) ? RW'(off_t) : {RW{1'b1}};
    end
  endtask

  task automatic model_update();
    logic [CC-1:0] act;
    int was;
    act = tdd_channel ^ m_pol;
    was = m_state;
    if (enable && sync && m_state == 2) begin
      model_close();
      if (m_valid && !meas_ack) m_ovf = 1'b1;
      else if (m_valid && meas_ack) m_ovf = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid && meas_ack) begin
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end
    if (!enable) begin
      m_state = 0;
      hist.delete();
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (sync) begin
      hist.delete();
      hist.push_back(act);
      m_state = 2;
    end else if (m_state == 2) begin
      hist.push_back(act);
    end
    if (was == 0) m_pol = ch_pol;
  endtask

  task automatic compare_all();
    chk("state", wide_t'(state), wide_t'(m_state[1:0]));
    chk("meas_valid", wide_t'(meas_valid), wide_t'(m_valid));
    chk("meas_overflow", wide_t'(meas_overflow), wide_t'(m_ovf));
    chk("frame_length", wide_t'(frame_length), wide_t'(e_len));
    chk("t_on", t_on, e_on);
    chk("t_off", t_off, e_off);
    chk("ch_seen", wide_t'(ch_seen), wide_t'(e_seen));
    chk("ch_multi", wide_t'(ch_multi), wide_t'(e_multi));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [CC-1:0] wave(input int c);
    logic [CC-1:0] w;
    w = '0;
    w[0] = (c >= 30 && c < 60);
    w[1] = !(c >= 15 && c < 25);
    w[2] = (c >= 5 && c < 17);
    w[4] = (c >= 13 && c < 15) || (c >= 19 && c < 22);
    w[5] = (c >= 140 && c < 145) || (c >= 147 && c < 149);
    w[6] = (c >= 175 && c < 200);
    w[7] = (c >= 232 && c < 240) || (c >= 265 && c < 270);
    return w;
  endfunction

  function automatic logic [RW-1:0] slot(input logic [WW-1:0] v, input int i);
    return v[i*RW +: RW];
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; sync = 1'b0; meas_ack = 1'b0;
    ch_pol = 8'h02; tdd_channel = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset t_on literal", t_on, {WW{1'b1}});
    rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      cyc = c;
      enable   = !(c >= 200 && c < 203);
      sync     = (c == 10 || c == 110 || c == 130 || c == 150 || c == 170 ||
                  c == 190 || c == 201 || c == 210 || c == 230 || c == 260 || c == 280);
      meas_ack = (c == 155 || c == 158 || c == 190 || c == 205);
      ch_pol   = (c >= 120 && c < 180) ? 8'h06 : 8'h02;
      tdd_channel = wave(c);
      if (c == 245) begin
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all();
        chk("async rst valid", wide_t'(meas_valid), wide_t'(1'b0));
        chk("async rst state", wide_t'(state), wide_t'(2'd0));
        chk("async rst t_off", t_off, {WW{1'b1}});
      end
      if (c == 247) rst = 1'b0;
      step();
      case (c)
        9: begin
          chk("armed state", wide_t'(state), wide_t'(2'd1));
          chk("armed valid", wide_t'(meas_valid), wide_t'(1'b0));
        end
        10: chk("open no result", wide_t'(meas_valid), wide_t'(1'b0));
        110: begin
          chk("f1 valid", wide_t'(meas_valid), wide_t'(1'b1));
          chk("f1 len", wide_t'(frame_length), wide_t'(32'd100));
          chk("f1 on0", wide_t'(slot(t_on, 0)), wide_t'(32'd20));
          chk("f1 off0", wide_t'(slot(t_off, 0)), wide_t'(32'd50));
          chk("f1 on1", wide_t'(slot(t_on, 1)), wide_t'(32'd5));
          chk("f1 off1", wide_t'(slot(t_off, 1)), wide_t'(32'd15));
          chk("f1 on2", wide_t'(slot(t_on, 2)), wide_t'(32'd0));
          chk("f1 off2", wide_t'(slot(t_off, 2)), wide_t'(32'd7));
          chk("f1 on3", wide_t'(slot(t_on, 3)), wide_t'(32'hFFFF_FFFF));
          chk("f1 off3", wide_t'(slot(t_off, 3)), wide_t'(32'hFFFF_FFFF));
          chk("f1 on4", wide_t'(slot(t_on, 4)), wide_t'(32'd3));
          chk("f1 off4", wide_t'(slot(t_off, 4)), wide_t'(32'd5));
          chk("f1 seen", wide_t'(ch_seen), wide_t'(8'h17));
          chk("f1 multi", wide_t'(ch_multi), wide_t'(8'h10));
        end
        150: begin
          chk("f3 overflow", wide_t'(meas_overflow), wide_t'(1'b1));
          chk("f3 len", wide_t'(frame_length), wide_t'(32'd20));
          chk("f3 on5", wide_t'(slot(t_on, 5)), wide_t'(32'd10));
          chk("f3 off5", wide_t'(slot(t_off, 5)), wide_t'(32'd15));
          chk("f3 multi", wide_t'(ch_multi), wide_t'(8'h20));
        end
        155: begin
          chk("ack valid", wide_t'(meas_valid), wide_t'(1'b0));
          chk("ack overflow", wide_t'(meas_overflow), wide_t'(1'b0));
        end
        190: begin
          chk("close+ack valid", wide_t'(meas_valid), wide_t'(1'b1));
          chk("close+ack overflow", wide_t'(meas_overflow), wide_t'(1'b0));
          chk("f5 on6", wide_t'(slot(t_on, 6)), wide_t'(32'd5));
          chk("f5 off6", wide_t'(slot(t_off, 6)), wide_t'(32'hFFFF_FFFF));
        end
        200: begin
          chk("disable state", wide_t'(state), wide_t'(2'd0));
          chk("disable keeps valid", wide_t'(meas_valid), wide_t'(1'b1));
        end
        210: chk("reopen no result", wide_t'(meas_valid), wide_t'(1'b0));
        260: chk("post-rst open no result", wide_t'(meas_valid), wide_t'(1'b0));
        280: begin
          chk("f7 len", wide_t'(frame_length), wide_t'(32'd20));
          chk("f7 on7", wide_t'(slot(t_on, 7)), wide_t'(32'd5));
          chk("f7 off7", wide_t'(slot(t_off, 7)), wide_t'(32'd10));
          chk("f7 valid", wide_t'(meas_valid), wide_t'(1'b1));
        end
        default: ;
      endcase
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_tdd_monitor.md
Name: axi_tdd_monitor

Overview:
- Receive-side counterpart of the TDD timing generator: observes the frame sync pulse and the TDD channel outputs, and decodes them back into timing values.
- Per frame it reports frame length plus the first on and off offsets of every channel, expressed in the generator's counter units.
- Sits in loopback or board-level verification paths, and beside remote TDD consumers to check the received timing.
- Results are handed to a register map through a valid/ack handshake.

Parameters:
- CHANNEL_COUNT, 8, number of monitored channels (1..32)
- REGISTER_WIDTH, 32, width of the cycle counter and every reported timing value
- DEFAULT_POLARITY, 8'h00, reset value of ch_pol_q; bit i=1 means channel i is active-low

Ports:
- clk  input  1  monitor clock, same domain as the observed signals
- rst  input  1  asynchronous active-high reset
- enable  input  1  monitor enable, level
- sync  input  1  frame-start pulse, one cycle
- ch_pol  input  CHANNEL_COUNT  active polarity per channel, sampled into ch_pol_q only in IDLE
- tdd_channel  input  CHANNEL_COUNT  observed channel levels
- meas_ack  input  1  consumer acknowledge of the current result set
- meas_valid  output  1  result set available, held until acknowledged
- meas_overflow  output  1  sticky: a result set was overwritten while unacknowledged
- frame_length  output  REGISTER_WIDTH  cycles between the last two syncs
- t_on  output  CHANNEL_COUNT*REGISTER_WIDTH  first activation offset; channel i is at [i*RW +: RW]
- t_off  output  CHANNEL_COUNT*REGISTER_WIDTH  first deactivation offset
- ch_seen  output  CHANNEL_COUNT  channel was active at some point in the frame
- ch_multi  output  CHANNEL_COUNT  channel had more than one activation in the frame
- state  output  2  FSM state: IDLE=0, ARMED=1, RUN=2

Behaviour:
- Reset values:
  - FSM=IDLE; counter=0; ch_pol_q=DEFAULT_POLARITY.
  - All outputs 0, except t_on and t_off, which reset to all-ones.
- Active level: act_i = tdd_channel[i] XOR ch_pol_q[i]. The previous-cycle level prev_i is registered every cycle in every state.
- FSM:
  - IDLE to ARMED when enable=1.
  - ARMED to RUN on sync=1.
  - Any state to IDLE in the first cycle enable=0. The in-progress frame is discarded; held results and meas_valid are kept.
- Counter:
  - Time value of the current cycle: now = sync ? 0 : counter.
  - In ARMED or RUN with sync=1: counter<=1.
  - In RUN: counter increments, saturating at all-ones. A saturated frame is reported with frame_length all-ones.
- Capture, RUN and ARMED-to-RUN cycles, using now:
  - Rise (act_i & ~prev_i): on the first rise of the frame, shadow t_on_i<=now. On any later rise, shadow multi_i<=1.
  - At sync, if act_i & prev_i (the channel is already active across the boundary), the frame records t_on_i=0.
  - Fall (~act_i & prev_i) after a recorded on, first time only: shadow t_off_i<=now.
  - An edge in the sync cycle belongs to the new frame, at time 0.
- Frame close, on sync while in RUN:
  - Output registers load the shadows: frame_length<=counter; ch_seen_i = on recorded; channels with no on report t_on=all-ones; channels with no off report t_off=all-ones.
  - Shadows are then reinitialised for the new frame.
  - meas_valid<=1 one cycle after the closing sync.
- Handshake:
  - meas_valid drops the cycle after meas_ack=1 while valid.
  - A frame close while meas_valid=1 and no same-cycle ack overwrites the outputs and sets meas_overflow. It stays set until the next accepted ack.
  - Close and ack in the same cycle: the new results load, meas_valid stays 1, and no overflow is flagged.
- Closed frames always come from RUN. The first sync after ARMED opens a frame and produces no result.

Test Plan:
- enable=1; syncs at cycles 10 and 110; ch0 active from 30 to 60 → meas_valid at cycle 111; frame_length=100; t_on[0]=20, t_off[0]=50; ch_seen[0]=1; ch_multi[0]=0.
- ch_pol[1]=1; tdd_channel[1] low from 15 to 25 inside the same frame → t_on[1]=5, t_off[1]=15.
- ch2 held active across sync, then falls at offset 7; ch3 never toggles → t_on[2]=0, t_off[2]=7; ch3 reports ch_seen=0 with t_on and t_off all-ones.
- ch4 pulses twice in one frame, at offsets 3–5 and 9–12 → t_on=3, t_off=5, ch_multi[4]=1.
- Three frames closed with no ack → meas_overflow=1; one ack → meas_valid=0 and meas_overflow=0 next cycle; close and ack in the same cycle → valid stays 1, no overflow.
- enable dropped mid-frame, or rst asserted asynchronously mid-frame → state=IDLE; with rst, all outputs return to reset values immediately; the next first sync after re-enable produces no result.
